lfsr_seq_ctrl: RTL and testbench
================================

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_BITS, default 16, the LFSR width (legal range 3..32).
REQ-002 SHALL have parameter CNT_W, default 16, the run-length counter width.
REQ-003 SHALL have port i_Clk, input, 1 bit: clock. All state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high; clock i_Clk.
REQ-005 SHALL have port i_start, input, 1 bit: start-request pulse.
REQ-006 SHALL have port i_seed, input, NUM_BITS bits: seed, sampled on an accepted i_start.
REQ-007 SHALL have port i_run_len, input, CNT_W bits: number of output words, sampled on an accepted i_start.
REQ-008 SHALL have port i_master_key_ready, input, 1 bit: alarm-clear qualifier.
REQ-009 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port o_data, output, NUM_BITS bits: current LFSR word.
REQ-011 SHALL have port o_data_valid, output, 1 bit: o_data is a sequence word.
REQ-012 SHALL have port o_done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-013 SHALL have port o_seed_err, output, 1 bit: one-cycle pulse on a lock-up seed.
REQ-014 SHALL have port o_alarm, output, 1 bit: fault alarm.

Function
REQ-015 SHALL use the FSM states IDLE, SEED, RUN, DONE and ALARM.
REQ-016 SHALL, in IDLE with i_start=1, latch i_seed and i_run_len and go to SEED on the next cycle.
REQ-017 SHALL ignore i_start in every state other than IDLE; no queuing.
REQ-018 SHALL, in SEED, drive the core enable and seed-valid high for exactly one cycle, then go to RUN, or to DONE if the latched run_len is 0.
REQ-019 SHALL, in RUN, enable the core every cycle, hold o_data_valid high, and decrement the counter each cycle.
REQ-020 SHALL make RUN last exactly run_len cycles.
REQ-021 SHALL output, in the first RUN cycle, o_data equal to the seed, followed by successive XNOR-feedback states.
REQ-022 SHALL, when the counter reaches 1 in RUN, go to DONE on the next edge.
REQ-023 SHALL, in DONE, pulse o_done high for one cycle, then go to IDLE.
REQ-024 SHALL make the start-to-first-valid-word latency exactly 2 cycles.
REQ-025 SHALL replace an all-ones seed (the XNOR lock-up state) with all-zeros, and pulse o_seed_err in the SEED cycle.
REQ-026 SHALL hold o_data_valid low outside RUN; o_data is don't-care while o_data_valid is low.
REQ-027 SHALL allow a run_len equal to all-ones, giving 2^CNT_W-1 words with no counter wrap.
REQ-028 SHALL hold the core (enable low) in IDLE, DONE and ALARM.

Reset
REQ-029 SHALL, on i_rst=1, force state IDLE, counter 0, core register 0, and all outputs 0.
REQ-030 SHALL give i_rst priority over all other inputs, including mid-RUN and in ALARM.

Configuration
REQ-031 SHALL, with LFSR_SEQ_SHADOW_EN defined, instantiate a second identical core driven by identical controls.
REQ-032 SHALL, with LFSR_SEQ_SHADOW_EN defined, compare the two core outputs every cycle.
REQ-033 SHALL, with LFSR_SEQ_SHADOW_EN defined, on any mismatch go to ALARM, set o_alarm=1 and abort the run without an o_done pulse.
REQ-034 SHALL, with LFSR_SEQ_SHADOW_EN defined, stay in ALARM until i_master_key_ready=1, then clear o_alarm and go to IDLE the next cycle.
REQ-035 SHALL, without LFSR_SEQ_SHADOW_EN, have no shadow core, tie o_alarm to 0, and make ALARM unreachable.

Structure
REQ-036 SHALL place the state-encoding localparams and the per-width XNOR tap table in the shared package lfsr_pkg.
REQ-037 SHALL implement the shift register as sub-module lfsr_core (enable, seed-valid, seed, synchronous reset, data out), instantiated once, or twice under REQ-031.

Verification
REQ-038 SHALL verify, with NUM_BITS=4, seed=0x0, run_len=3 and start at cycle t: o_data_valid high at t+2..t+4 with data 0x0, 0x1, 0x3, and o_done pulsed at t+5.
REQ-039 SHALL verify that seed=0xF with run_len=2 gives an o_seed_err pulse and data 0x0, 0x1.
REQ-040 SHALL verify that run_len=0 gives SEED then DONE, no valid words, and o_done at t+2.
REQ-041 SHALL verify that i_start asserted mid-RUN is ignored (word count unchanged), and that i_rst mid-RUN gives all outputs 0 the next cycle.
REQ-042 SHALL verify, with LFSR_SEQ_SHADOW_EN, that a forced shadow bit-flip at RUN word 2 gives o_alarm=1 the next cycle and no o_done.
REQ-043 SHALL verify, with LFSR_SEQ_SHADOW_EN, that o_alarm holds until i_master_key_ready=1, then o_alarm=0 and o_busy=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR sequence controller.
//   ST_* / state_t : controller state encoding
//   lfsr_taps(n)   : XNOR feedback tap mask for an n-bit LFSR (n = 3..32),
//                    bit k-1 set for tap k (maximal-length tap sets)
package lfsr_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEED  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ALARM = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SEED  = ST_SEED,
        RUN   = ST_RUN,
        DONE  = ST_DONE,
        ALARM = ST_ALARM
    } state_t;

    function automatic logic [31:0] tmask(input int a, input int b, input int c, input int d);
        logic [31:0] m;
        m = '0;
        if (a > 0) m[a-1] = 1'b1;
        if (b > 0) m[b-1] = 1'b1;
        if (c > 0) m[c-1] = 1'b1;
        if (d > 0) m[d-1] = 1'b1;
        return m;
    endfunction

    // Every entry has an even tap count, so all-ones is the lock-up state.
    function automatic logic [31:0] lfsr_taps(input int n);
        logic [31:0] t;
        case (n)
            3:  t = tmask(3, 2, 0, 0);
            4:  t = tmask(4, 3, 0, 0);
            5:  t = tmask(5, 3, 0, 0);
            6:  t = tmask(6, 5, 0, 0);
            7:  t = tmask(7, 6, 0, 0);
            8:  t = tmask(8, 6, 5, 4);
            9:  t = tmask(9, 5, 0, 0);
            10: t = tmask(10, 7, 0, 0);
            11: t = tmask(11, 9, 0, 0);
            12: t = tmask(12, 6, 4, 1);
            13: t = tmask(13, 4, 3, 1);
            14: t = tmask(14, 5, 3, 1);
            15: t = tmask(15, 14, 0, 0);
            16: t = tmask(16, 15, 13, 4);
            17: t = tmask(17, 14, 0, 0);
            18: t = tmask(18, 11, 0, 0);
            19: t = tmask(19, 6, 2, 1);
            20: t = tmask(20, 17, 0, 0);
            21: t = tmask(21, 19, 0, 0);
            22: t = tmask(22, 21, 0, 0);
            23: t = tmask(23, 18, 0, 0);
            24: t = tmask(24, 23, 22, 17);
            25: t = tmask(25, 22, 0, 0);
            26: t = tmask(26, 6, 2, 1);
            27: t = tmask(27, 5, 2, 1);
            28: t = tmask(28, 25, 0, 0);
            29: t = tmask(29, 27, 0, 0);
            30: t = tmask(30, 6, 4, 1);
            31: t = tmask(31, 28, 0, 0);
            32: t = tmask(32, 22, 2, 1);
            default: t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: NUM_BITS-wide XNOR-feedback Fibonacci LFSR, shifting left.
//   i_Clk, i_rst : clock, synchronous active-high reset (register -> 0)
//   en           : advance / load enable
//   seed_vld     : with en, load seed instead of shifting
//   seed         : load value
//   data         : current register value
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = 16
) (
    input  logic                i_Clk,
    input  logic                i_rst,
    input  logic                en,
    input  logic                seed_vld,
    input  logic [NUM_BITS-1:0] seed,
    output logic [NUM_BITS-1:0] data
);

    localparam logic [31:0]         TAPS_ALL = lfsr_taps(NUM_BITS);
    localparam logic [NUM_BITS-1:0] TAPS     = TAPS_ALL[NUM_BITS-1:0];

    logic fb;
    assign fb = ~^(data & TAPS);

    always_ff @(posedge i_Clk) begin
        if (i_rst)
            data <= '0;
        else if (en)
            data <= seed_vld ? seed : {data[NUM_BITS-2:0], fb};
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: runs an LFSR for i_run_len words from a given seed.
//   i_Clk, i_rst        : clock, synchronous active-high reset
//   i_start             : start request (honoured only in IDLE)
//   i_seed, i_run_len   : sampled on an accepted start
//   i_master_key_ready  : releases the controller from ALARM
//   o_busy              : not IDLE
//   o_data/o_data_valid : sequence word, valid throughout RUN
//   o_done              : one-cycle pulse closing a run
//   o_seed_err          : one-cycle pulse when the lock-up (all-ones) seed was replaced
//   o_alarm             : main/shadow core mismatch detected
// Build option LFSR_SEQ_SHADOW_EN adds a lock-step shadow core and the ALARM
// path; without it o_alarm is constant 0 and ALARM is never entered.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = 16,
    parameter int CNT_W    = 16
) (
    input  logic                i_Clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [NUM_BITS-1:0] i_seed,
    input  logic [CNT_W-1:0]    i_run_len,
    input  logic                i_master_key_ready,
    output logic                o_busy,
    output logic [NUM_BITS-1:0] o_data,
    output logic                o_data_valid,
    output logic                o_done,
    output logic                o_seed_err,
    output logic                o_alarm
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_BITS-1:0] seed_q, core_seed, main_data;
    logic                lockup, core_en, seed_vld;

    // All-ones never leaves itself under XNOR feedback; load zero instead.
    assign lockup    = &seed_q;
    assign core_seed = lockup ? '0 : seed_q;

    always_ff @(posedge i_Clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && i_start) begin
                cnt_q  <= i_run_len;
                seed_q <= i_seed;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

    lfsr_core #(.NUM_BITS(NUM_BITS)) u_main (
        .i_Clk    (i_Clk),
        .i_rst    (i_rst),
        .en       (core_en),
        .seed_vld (seed_vld),
        .seed     (core_seed),
        .data     (main_data)
    );

`ifdef LFSR_SEQ_SHADOW_EN
    logic [NUM_BITS-1:0] shadow_data;
    logic                mismatch;

    lfsr_core #(.NUM_BITS(NUM_BITS)) u_shadow (
        .i_Clk    (i_Clk),
        .i_rst    (i_rst),
        .en       (core_en),
        .seed_vld (seed_vld),
        .seed     (core_seed),
        .data     (shadow_data)
    );

    assign mismatch = (main_data != shadow_data);
    assign o_alarm  = (state_q == ALARM);
`else
    assign o_alarm  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        core_en      = 1'b0;
        seed_vld     = 1'b0;
        o_busy       = 1'b1;
        o_data_valid = 1'b0;
        o_done       = 1'b0;
        o_seed_err   = 1'b0;
        case (state_q)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_d = SEED;
            end
            SEED: begin
                core_en    = 1'b1;
                seed_vld   = 1'b1;
                o_seed_err = lockup;
                state_d    = (cnt_q == '0) ? DONE : RUN;
            end
            RUN: begin
                core_en      = 1'b1;
                o_data_valid = 1'b1;
                if (cnt_q == CNT_ONE) state_d = DONE;
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            ALARM: begin
                if (i_master_key_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef LFSR_SEQ_SHADOW_EN
        // A mismatch aborts whatever is in flight; no done pulse for that run.
        if (mismatch && state_q != ALARM) begin
            state_d = ALARM;
            o_done  = 1'b0;
        end
`endif
    end

    assign o_data = main_data;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl: scoreboard bench for lfsr_seq_ctrl at NUM_BITS=4, CNT_W=8.
// Expected words are generated from a 4-bit XNOR model (taps 4,3) when a run
// is started and popped by a negedge monitor whenever o_data_valid is high.
module tb_lfsr_seq_ctrl;

    localparam int NB = 4;
    localparam int CW = 8;

    logic          i_Clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic [NB-1:0] i_seed = '0;
    logic [CW-1:0] i_run_len = '0;
    logic          i_master_key_ready = 1'b0;
    logic          o_busy, o_data_valid, o_done, o_seed_err, o_alarm;
    logic [NB-1:0] o_data;

    int checks = 0;
    int errors = 0;
    int word_cnt = 0;
    int done_cnt = 0;
    logic [NB-1:0] exp_q[$];

    lfsr_seq_ctrl #(.NUM_BITS(NB), .CNT_W(CW)) dut (
        .i_Clk              (i_Clk),
        .i_rst              (i_rst),
        .i_start            (i_start),
        .i_seed             (i_seed),
        .i_run_len          (i_run_len),
        .i_master_key_ready (i_master_key_ready),
        .o_busy             (o_busy),
        .o_data             (o_data),
        .o_data_valid       (o_data_valid),
        .o_done             (o_done),
        .o_seed_err         (o_seed_err),
        .o_alarm            (o_alarm)
    );

    always #5 i_Clk = ~i_Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [NB-1:0] model_next(input logic [NB-1:0] r);
        return {r[NB-2:0], ~(r[3] ^ r[2])};
    endfunction

    // Scoreboard consumer.
    always @(negedge i_Clk) begin
        if (o_done) done_cnt++;
        if (o_data_valid) begin
            logic [NB-1:0] e;
            word_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected got %h required none", o_data);
            end else begin
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    errors++;
                    $display("FAIL word_data got %h required %h", o_data, e);
                end
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the SEED cycle.
    task automatic start_run(input logic [NB-1:0] seed, input logic [CW-1:0] len);
        logic [NB-1:0] r;
        i_start   = 1'b1;
        i_seed    = seed;
        i_run_len = len;
        r = (seed == '1) ? '0 : seed;
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(r);
            r = model_next(r);
        end
        @(negedge i_Clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_Clk);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (3) @(negedge i_Clk);
        checks++;
        if ({o_busy, o_data, o_data_valid, o_done, o_seed_err, o_alarm} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b data=%h vld=%b done=%b serr=%b alarm=%b required all 0",
                     o_busy, o_data, o_data_valid, o_done, o_seed_err, o_alarm);
        end
        i_rst = 1'b0;
        @(negedge i_Clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got %b required 0", o_busy);
        end
    endtask

    task automatic test_basic;
        start_run(4'h0, 8'd3);
        checks++;
        if (o_busy !== 1'b1 || o_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_seed_cycle got busy=%b vld=%b required 1 0", o_busy, o_data_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge i_Clk);
            checks++;
            if (o_data_valid !== 1'b1) begin
                errors++;
                $display("FAIL basic_valid_t%0d got %b required 1", i + 2, o_data_valid);
            end
        end
        @(negedge i_Clk);
        checks++;
        if (o_done !== 1'b1 || o_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_t5 got done=%b vld=%b required 1 0", o_done, o_data_valid);
        end
        @(negedge i_Clk);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_end got done=%b busy=%b left=%0d required 0 0 0", o_done, o_busy, exp_q.size());
        end
    endtask

    task automatic test_lockup_seed;
        bit ok;
        start_run(4'hF, 8'd2);
        checks++;
        if (o_seed_err !== 1'b1) begin
            errors++;
            $display("FAIL lockup_seed_err got %b required 1", o_seed_err);
        end
        @(negedge i_Clk);
        checks++;
        if (o_seed_err !== 1'b0) begin
            errors++;
            $display("FAIL lockup_err_width got %b required 0", o_seed_err);
        end
        wait_done(10, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL lockup_done got done_seen=%0d left=%0d required 1 0", ok, exp_q.size());
        end
        @(negedge i_Clk);
    endtask

    task automatic test_zero_len;
        int w0;
        w0 = word_cnt;
        start_run(4'h5, 8'd0);
        checks++;
        if (o_busy !== 1'b1 || o_data_valid !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_seed_cycle got busy=%b vld=%b done=%b required 1 0 0", o_busy, o_data_valid, o_done);
        end
        @(negedge i_Clk);
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done_t2 got %b required 1", o_done);
        end
        @(negedge i_Clk);
        checks++;
        if (o_busy !== 1'b0 || word_cnt != w0) begin
            errors++;
            $display("FAIL zero_end got busy=%b words=%0d required 0 0", o_busy, word_cnt - w0);
        end
    endtask

    task automatic test_start_ignored;
        int w0;
        bit ok;
        start_run(4'h5, 8'd4);
        w0 = word_cnt;
        @(negedge i_Clk);
        i_start   = 1'b1;
        i_seed    = 4'h9;
        i_run_len = 8'd7;
        @(negedge i_Clk);
        i_start = 1'b0;
        wait_done(20, ok);
        checks++;
        if (!ok || word_cnt - w0 != 4) begin
            errors++;
            $display("FAIL start_ignored got done_seen=%0d words=%0d required 1 4", ok, word_cnt - w0);
        end
        repeat (2) @(negedge i_Clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_idle got busy=%b required 0", o_busy);
        end
    endtask

    task automatic test_rst_mid_run;
        start_run(4'h1, 8'd10);
        repeat (3) @(negedge i_Clk);
        i_rst = 1'b1;
        @(negedge i_Clk);
        checks++;
        if ({o_busy, o_data, o_data_valid, o_done, o_seed_err, o_alarm} !== '0) begin
            errors++;
            $display("FAIL rst_mid_run got busy=%b data=%h vld=%b done=%b serr=%b alarm=%b required all 0",
                     o_busy, o_data, o_data_valid, o_done, o_seed_err, o_alarm);
        end
        exp_q.delete();
        i_rst = 1'b0;
        @(negedge i_Clk);
    endtask

    task automatic test_max_len;
        int w0;
        bit ok;
        start_run(4'h3, 8'hFF);
        w0 = word_cnt;
        wait_done(400, ok);
        checks++;
        if (!ok || word_cnt - w0 != 255) begin
            errors++;
            $display("FAIL max_len got done_seen=%0d words=%0d required 1 255", ok, word_cnt - w0);
        end
        @(negedge i_Clk);
    endtask

    task automatic test_back_to_back;
        int w0;
        bit ok;
        w0 = word_cnt;
        start_run(4'h6, 8'd2);
        wait_done(10, ok);
        // Hold start through DONE (must be ignored) and the following IDLE cycle.
        start_run(4'hA, 8'd2);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_ignores_start got busy=%b required 0", o_busy);
        end
        i_start = 1'b1;
        @(negedge i_Clk);
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_seed got busy=%b vld=%b required 1 0", o_busy, o_data_valid);
        end
        wait_done(10, ok);
        checks++;
        if (!ok || word_cnt - w0 != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_words got done_seen=%0d words=%0d left=%0d required 1 4 0", ok, word_cnt - w0, exp_q.size());
        end
        @(negedge i_Clk);
    endtask

`ifdef LFSR_SEQ_SHADOW_EN
    task automatic test_shadow_alarm;
        int d0;
        logic [NB-1:0] bad;
        d0 = done_cnt;
        start_run(4'h2, 8'd6);
        repeat (2) @(negedge i_Clk);
        bad = dut.u_main.data ^ 4'h1;
        force dut.u_shadow.data = bad;
        @(negedge i_Clk);
        checks++;
        if (o_alarm !== 1'b1 || o_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL shadow_alarm got alarm=%b vld=%b required 1 0", o_alarm, o_data_valid);
        end
        release dut.u_shadow.data;
        exp_q.delete();
        repeat (4) @(negedge i_Clk);
        checks++;
        if (o_alarm !== 1'b1 || done_cnt != d0) begin
            errors++;
            $display("FAIL shadow_alarm_hold got alarm=%b dones=%0d required 1 0", o_alarm, done_cnt - d0);
        end
        i_master_key_ready = 1'b1;
        @(negedge i_Clk);
        i_master_key_ready = 1'b0;
        checks++;
        if (o_alarm !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL shadow_clear got alarm=%b busy=%b required 0 0", o_alarm, o_busy);
        end
        i_rst = 1'b1;
        @(negedge i_Clk);
        i_rst = 1'b0;
        @(negedge i_Clk);
    endtask
`endif

    initial begin
        @(negedge i_Clk);
        test_reset();
        test_basic();
        test_lockup_seed();
        test_zero_len();
        test_start_ignored();
        test_rst_mid_run();
        test_max_len();
        test_back_to_back();
`ifdef LFSR_SEQ_SHADOW_EN
        test_shadow_alarm();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
